// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and scoreboard entry.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pipeline_pkg;

    // Scoreboard register fields are stored at this width. The hazard unit
    // zero-extends its REG_AW-wide ports into it, so REG_AW must not exceed it.
    localparam int SB_AW = 8;

    typedef logic [SB_AW-1:0] reg_t;

    // EX operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // One in-flight instruction as seen by the hazard unit.
    typedef struct packed {
        logic valid;
        reg_t rd;
        reg_t rs1;
        reg_t rs2;
        logic use_rs1;
        logic use_rs2;
        logic reg_write;
        logic mem_read;
    } sb_entry_t;

    // True when src will write register rs and the consumer actually reads rs.
    // Loads are excluded unless allow_load is set; x0 never matches.
    function automatic logic fwd_hit(input sb_entry_t src, input reg_t rs,
                                     input logic use_rs, input logic allow_load);
        return src.valid && src.reg_write && (allow_load || !src.mem_read) &&
               (src.rd != '0) && use_rs && (src.rd == rs);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
// Latency: count visible the cycle after inc.
// Backpressure: none; inc is sampled every cycle, ignored once saturated.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall/flush/hold enables, EX forwarding selects, perf counters.
// Latency: control and forwarding outputs are combinational (zero cycles); counters one cycle.
// Backpressure: mem_busy freezes everything; load-use stalls IF/ID for exactly one cycle.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_hold,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t id_ent;
    logic      lu_hit, load_use, br_flush;

    // Operand usage of the older stages only matters while they sit in EX.
    wire unused_sb = ^{mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2,
                       wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2};

    // Pack the ID-stage instruction into a scoreboard entry.
    always_comb begin
        id_ent           = '0;
        id_ent.valid     = id_valid;
        id_ent.rd        = reg_t'(id_rd);
        id_ent.rs1       = reg_t'(id_rs1);
        id_ent.rs2       = reg_t'(id_rs2);
        id_ent.use_rs1   = id_use_rs1;
        id_ent.use_rs2   = id_use_rs2;
        id_ent.reg_write = id_reg_write;
        id_ent.mem_read  = id_mem_read;
    end

    // Hazard detection, ordered mem_busy > branch flush > load-use.
    always_comb begin
        lu_hit = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0) &&
                 id_valid &&
                 ((id_use_rs1 && (reg_t'(id_rs1) == ex_q.rd)) ||
                  (id_use_rs2 && (reg_t'(id_rs2) == ex_q.rd)));
        br_flush = !reset && !mem_busy && ex_q.valid && ex_branch_taken;
        load_use = !reset && !mem_busy && !br_flush && lu_hit;
    end

    // Pipeline enables; reset forces a squashed, non-advancing front end.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_hold  = 1'b1;
        end else if (br_flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // EX operand forwarding: MEM (non-load) beats WB (loads allowed) beats regfile.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset) begin
            if (fwd_hit(mem_q, ex_q.rs1, ex_q.use_rs1, 1'b0))     fwd_a = FWD_MEM;
            else if (fwd_hit(wb_q, ex_q.rs1, ex_q.use_rs1, 1'b1)) fwd_a = FWD_WB;
            if (fwd_hit(mem_q, ex_q.rs2, ex_q.use_rs2, 1'b0))     fwd_b = FWD_MEM;
            else if (fwd_hit(wb_q, ex_q.rs2, ex_q.use_rs2, 1'b1)) fwd_b = FWD_WB;
        end
    end

    // Scoreboard shift: frozen on mem_busy, EX squashed on flush or load-use bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (br_flush || load_use) ? sb_entry_t'('0) : id_ent;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!reset && (mem_busy || load_use)),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance plus a CNT_W=4 instance on shared inputs.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Every expected value is hand-derived from the pipeline behaviour.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic       ex_branch_taken, mem_busy;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, ex_mem_hold4;
    logic [1:0]  fwd_a4, fwd_b4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
        .id_ex_bubble(id_ex_bubble4), .ex_mem_hold(ex_mem_hold4),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ID-stage instruction: valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read.
    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic [4:0] d,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = d; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Enables as one vector: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold}.
    function automatic logic [31:0] ctl();
        return {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
    endtask

    localparam logic [31:0] CTL_RUN   = 32'b11000;
    localparam logic [31:0] CTL_RST   = 32'b00110;
    localparam logic [31:0] CTL_BUSY  = 32'b00001;
    localparam logic [31:0] CTL_FLUSH = 32'b11110;
    localparam logic [31:0] CTL_LU    = 32'b00010;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
        ex_branch_taken = 1'b1;
        mem_busy = 1'b1;
        tick();
        #1;
        chk("reset_ctl", ctl(), CTL_RST);
        chk("reset_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("post_reset_run", ctl(), CTL_RUN);
        chk("post_reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("post_reset_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();

        // Load x5, then a consumer of x5: one stall cycle, then WB forward.
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        chk("lu_ctl", ctl(), CTL_LU);
        tick();
        #1;
        chk("lu_one_cycle", ctl(), CTL_RUN);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();
        idle();
        #1;
        chk("lu_fwd_a_wb", 32'(fwd_a), 32'd1);
        chk("lu_fwd_b_rf", 32'(fwd_b), 32'd0);
        tick(); tick(); tick();

        // ALU writes x7; next reads x7 twice (MEM forward); third reads x7 (WB forward).
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        chk("alu_no_stall", ctl(), CTL_RUN);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        #1;
        chk("alu_fwd_a_mem", 32'(fwd_a), 32'd2);
        chk("alu_fwd_b_mem", 32'(fwd_b), 32'd2);
        tick();
        idle();
        #1;
        chk("alu_fwd_a_wb", 32'(fwd_a), 32'd1);
        chk("alu_fwd_b_rf", 32'(fwd_b), 32'd0);
        tick(); tick(); tick();

        // Branch taken while a load-use is also present: flush wins.
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        chk("br_vs_lu_ctl", ctl(), CTL_FLUSH);
        tick();
        ex_branch_taken = 1'b0;
        #1;
        chk("br_ex_squashed", ctl(), CTL_RUN);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        idle();
        tick(); tick(); tick();

        // mem_busy for 3 cycles with a taken branch pending, flush on the 4th.
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        idle();
        mem_busy = 1'b1;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("busy_ctl_%0d", i), ctl(), CTL_BUSY);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        chk("busy_then_flush", ctl(), CTL_FLUSH);
        tick();
        ex_branch_taken = 1'b0;
        #1;
        chk("busy_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("busy_stall_cnt4", 32'(stall_cnt4), 32'd3);
        chk("busy_flush_cnt", 32'(flush_cnt), 32'd1);
        tick(); tick(); tick();

        // x0: ALU write x0, load x0, then read x0 twice -- no stall, no forward.
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        chk("x0_no_stall", ctl(), CTL_RUN);
        tick();
        idle();
        #1;
        chk("x0_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        tick(); tick(); tick();

        // 20 busy cycles: 4-bit counter saturates at 15; then reset mid-busy.
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
        chk("sat_stall_cnt16", 32'(stall_cnt), 32'd20);
        reset = 1'b1;
        #1;
        chk("reset_mid_busy_ctl", ctl(), CTL_RST);
        tick();
        reset = 1'b0;
        mem_busy = 1'b0;
        #1;
        chk("after_abort_run", ctl(), CTL_RUN);
        chk("after_abort_cnt4", 32'(stall_cnt4), 32'd0);
        chk("after_abort_cnt16", 32'(stall_cnt), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
